// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and next-PC select encoding for the fetch stage
package fetch_pkg;

    localparam int          IMEM_ADDR_W_DEF = 12;
    localparam logic [31:0] RESET_PC_DEF    = 32'd0;
    localparam logic [31:0] NOP_DEF         = 32'd0;

    // Next-state source for pc and the FD pair, listed in priority order
    typedef enum logic [2:0] {
        SEL_EX      = 3'd0,
        SEL_HOLD    = 3'd1,
        SEL_DEC     = 3'd2,
        SEL_REALIGN = 3'd3,
        SEL_SEQ     = 3'd4
    } sel_t;

endpackage

// File: rtl/fd_pair_latch.sv
// rtl/fd_pair_latch.sv - F/D pipeline latch holding two instructions and their PCs
module fd_pair_latch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP      = NOP_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  sel_t        sel,
    input  logic [31:0] q_top,
    input  logic [31:0] q_bot,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus1,
    output logic [31:0] instr_top,
    output logic [31:0] instr_bot,
    output logic [31:0] pc_top,
    output logic [31:0] pc_bot
);

    // Load each slot from the source picked by sel; flushed slots keep the squashed fetch PCs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_top <= NOP;
            instr_bot <= NOP;
            pc_top    <= RESET_PC;
            pc_bot    <= RESET_PC + 32'd1;
        end else begin
            case (sel)
                SEL_EX, SEL_DEC: begin
                    instr_top <= NOP;
                    instr_bot <= NOP;
                    pc_top    <= pc;
                    pc_bot    <= pc_plus1;
                end
                SEL_REALIGN: begin
                    instr_top <= instr_bot;
                    pc_top    <= pc_bot;
                    instr_bot <= q_top;
                    pc_bot    <= pc;
                end
                SEL_SEQ: begin
                    instr_top <= q_top;
                    instr_bot <= q_bot;
                    pc_top    <= pc;
                    pc_bot    <= pc_plus1;
                end
                default: begin
                    instr_top <= instr_top;
                    instr_bot <= instr_bot;
                    pc_top    <= pc_top;
                    pc_bot    <= pc_bot;
                end
            endcase
        end
    end

endmodule

// File: rtl/dual_fetch_unit.sv
// rtl/dual_fetch_unit.sv - dual-issue fetch stage: fetch PC, next-PC priority select, FD latch
module dual_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          IMEM_ADDR_W = IMEM_ADDR_W_DEF,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [31:0] NOP         = NOP_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [IMEM_ADDR_W-1:0] address_imem_top,
    output logic [IMEM_ADDR_W-1:0] address_imem_bot,
    input  logic [31:0]            q_imem_top,
    input  logic [31:0]            q_imem_bot,
    input  logic                   stall_all,
    input  logic                   stall_bot,
    input  logic                   dec_redirect,
    input  logic                   dec_redirect_bot,
    input  logic [31:0]            dec_target,
    input  logic                   ex_redirect,
    input  logic [31:0]            ex_target,
    output logic [31:0]            fd_instr_top,
    output logic [31:0]            fd_instr_bot,
    output logic [31:0]            fd_pc_top,
    output logic [31:0]            fd_pc_bot
);

    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] pc_plus2;
    logic [31:0] pc_next;
    sel_t        sel;

    assign pc_plus1         = pc + 32'd1;
    assign pc_plus2         = pc + 32'd2;
    assign address_imem_top = pc[IMEM_ADDR_W-1:0];
    assign address_imem_bot = pc_plus1[IMEM_ADDR_W-1:0];

    // Priority encoder: a top-slot redirect beats stall_bot, a bot-slot redirect waits for it
    always_comb begin
        sel = SEL_SEQ;
        if (ex_redirect)
            sel = SEL_EX;
        else if (stall_all)
            sel = SEL_HOLD;
        else if (dec_redirect && !dec_redirect_bot)
            sel = SEL_DEC;
        else if (stall_bot)
            sel = SEL_REALIGN;
        else if (dec_redirect)
            sel = SEL_DEC;
    end

    // Next-PC mux driven by the select
    always_comb begin
        pc_next = pc_plus2;
        case (sel)
            SEL_EX:      pc_next = ex_target;
            SEL_HOLD:    pc_next = pc;
            SEL_DEC:     pc_next = dec_target;
            SEL_REALIGN: pc_next = pc_plus1;
            default:     pc_next = pc_plus2;
        endcase
    end

    // Fetch PC register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    fd_pair_latch #(
        .RESET_PC (RESET_PC),
        .NOP      (NOP)
    ) u_fd_pair_latch (
        .clock     (clock),
        .reset     (reset),
        .sel       (sel),
        .q_top     (q_imem_top),
        .q_bot     (q_imem_bot),
        .pc        (pc),
        .pc_plus1  (pc_plus1),
        .instr_top (fd_instr_top),
        .instr_bot (fd_instr_bot),
        .pc_top    (fd_pc_top),
        .pc_bot    (fd_pc_bot)
    );

endmodule
